// File: rtl/riscv_imem_loader.sv
// riscv_imem_loader: length-prefixed byte stream to instruction memory writer, holds core in reset until loaded
module riscv_imem_loader #(
  parameter int N_WORDS = 64,
  parameter int AW = $clog2(N_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wd,
  output logic          core_rst,
  output logic          done,
  output logic          err
);
  typedef enum logic [2:0] {LEN0, LEN1, DATA, WRITE, DONE, ERR} state_t;
  state_t state;
  logic [15:0] cnt, wcnt, cnt_full;
  logic [1:0] bcnt;
  logic [31:0] word;
  assign cnt_full = {in_data, cnt[7:0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LEN0;
      cnt <= '0;
      wcnt <= '0;
      bcnt <= '0;
      word <= '0;
    end else begin
      case (state)
        LEN0: if (in_valid) begin
          cnt[7:0] <= in_data;
          state <= LEN1;
        end
        LEN1: if (in_valid) begin
          cnt[15:8] <= in_data;
          state <= cnt_full == 16'd0 ? DONE : 32'(cnt_full) > 32'(N_WORDS) ? ERR : DATA;
        end
        DATA: if (in_valid) begin
          // little-endian: each new byte enters at the top, so byte 0 ends up in [7:0]
          word <= {in_data, word[31:8]};
          bcnt <= bcnt + 2'd1;
          if (bcnt == 2'd3) state <= WRITE;
        end
        WRITE: begin
          wcnt <= wcnt + 16'd1;
          state <= wcnt + 16'd1 == cnt ? DONE : DATA;
        end
        default: ;
      endcase
    end
  end
  assign in_ready = state == LEN0 || state == LEN1 || state == DATA;
  assign mem_we = state == WRITE;
  assign mem_addr = wcnt[AW-1:0];
  assign mem_wd = word;
  assign core_rst = state != DONE;
  assign done = state == DONE;
  assign err = state == ERR;
endmodule

// File: tb/tb_riscv_imem_loader.sv
// tb_riscv_imem_loader: table-driven and randomized checks of the loader against a stream-parsing model
module tb_riscv_imem_loader;
  localparam int N = 64;
  localparam int AW = 6;
  logic clk = 0, rst = 1, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, mem_we, core_rst, done, err;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wd;

  riscv_imem_loader #(.N_WORDS(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .core_rst(core_rst),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  typedef struct {logic [AW-1:0] a; logic [31:0] d; int c;} wr_t;
  wr_t got_q[$];
  wr_t exp_q[$];
  bit exp_done, exp_err;
  int acc_cyc, end_cyc;

  always @(negedge clk) if (mem_we) begin
    got_q.push_back('{mem_addr, mem_wd, cyc});
    checks++;
    if (in_ready !== 1'b0 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL write_cycle in_ready=%0b core_rst=%0b required 0 1", in_ready, core_rst);
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", n, act, exp);
    end
  endtask

  // Parse the stream by its format rules: header count, then 4 LE bytes per word.
  task automatic model(input logic [7:0] q[$]);
    int c;
    exp_q.delete();
    c = int'(q[0]) + 256 * int'(q[1]);
    exp_done = c >= 1 && c <= N || c == 0;
    exp_err = c > N;
    if (!exp_err)
      for (int w = 0; w < c; w++)
        exp_q.push_back('{AW'(w), {q[2+4*w+3], q[2+4*w+2], q[2+4*w+1], q[2+4*w]}, 0});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_ctl", {in_ready, mem_we, core_rst, done, err}, 32'b10100);
    chk("reset_addr", 32'(mem_addr), 0);
    chk("reset_wd", mem_wd, 0);
    rst = 0;
    got_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    bit x = 0;
    while (!x) begin
      @(negedge clk);
      if (n++ > 2000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout byte=%0h never accepted", b);
        in_valid = 0;
        return;
      end
      if (int'($urandom_range(99)) < gap) begin
        in_valid = 0;
      end else begin
        in_valid = 1;
        in_data = b;
        x = in_ready;
        acc_cyc = cyc + 1;
        @(posedge clk);
      end
    end
  endtask

  task automatic send_stream(input logic [7:0] q[$], input int gap);
    foreach (q[i]) send_byte(q[i], gap);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || err)) begin
      if (n++ > 2000) begin
        checks++;
        errors++;
        $display("FAIL end_timeout done=%0b err=%0b required one set", done, err);
        return;
      end
      @(negedge clk);
    end
    end_cyc = cyc;
  endtask

  task automatic run_stream(input logic [7:0] q[$], input int gap);
    int n;
    model(q);
    do_reset();
    send_stream(q, gap);
    wait_end();
    n = got_q.size();
    chk("nwrites", n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      chk($sformatf("addr[%0d]", i), 32'(got_q[i].a), 32'(exp_q[i].a));
      chk($sformatf("data[%0d]", i), got_q[i].d, exp_q[i].d);
    end
    chk("done", 32'(done), 32'(exp_done));
    chk("err", 32'(err), 32'(exp_err));
    chk("core_rst", 32'(core_rst), 32'(!exp_done));
    chk("in_ready_end", 32'(in_ready), 0);
    repeat (5) @(negedge clk);
    chk("stable", {29'(got_q.size()), done, err, core_rst}, {29'(n), exp_done, exp_err, !exp_done});
  endtask

  typedef struct {int cnt; int gap; int mode; bit edone; bit eerr;} vec_t;
  vec_t vecs[9];

  task automatic run_vec(input vec_t v);
    logic [7:0] q[$];
    q = '{8'(v.cnt), 8'(v.cnt >> 8)};
    if (v.cnt <= N)
      for (int w = 0; w < v.cnt; w++)
        for (int k = 0; k < 4; k++)
          q.push_back(v.mode == 1 ? (k == 0 ? 8'(w) : 8'h00) : 8'($urandom));
    run_stream(q, v.gap);
    chk("vec_done", 32'(done), 32'(v.edone));
    chk("vec_err", 32'(err), 32'(v.eerr));
  endtask

  initial begin
    logic [7:0] s3[$];
    logic [7:0] part[$];
    bit bad;
    s3 = '{8'h03, 8'h00, 8'h63, 8'h4e, 8'h02, 8'h02, 8'h63, 8'h4c, 8'h00, 8'h02, 8'h63, 8'h48, 8'h40, 8'h00};

    // 3-word load, valid held high: exact data, latency, throughput, done timing
    run_stream(s3, 0);
    if (got_q.size() == 3) begin
      chk("w0", got_q[0].d, 32'h02024e63);
      chk("w1", got_q[1].d, 32'h02004c63);
      chk("w2", got_q[2].d, 32'h00404863);
      chk("spacing", 32'(got_q[1].c - got_q[0].c), 5);
    end
    chk("done_after_last_we", 32'(end_cyc), 32'(got_q.size() > 0 ? got_q[got_q.size()-1].c + 1 : -1));

    // same stream with gaps
    run_stream(s3, 50);

    // count 0, then bytes presented after done are never accepted
    run_stream('{8'h00, 8'h00}, 0);
    chk("cnt0_timing", 32'(end_cyc), 32'(acc_cyc));
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1;
      in_data = 8'(i);
      if (in_ready !== 1'b0) bad = 1;
    end
    @(negedge clk);
    in_valid = 0;
    chk("after_done_ready", 32'(bad), 0);
    chk("after_done_we", got_q.size(), 0);
    chk("after_done_done", 32'(done), 1);

    // count 65 rejected; err timing
    run_stream('{8'h41, 8'h00}, 0);
    chk("err_timing", 32'(end_cyc), 32'(acc_cyc));

    // 64 words equal to index
    run_vec('{64, 0, 1, 1, 0});
    if (got_q.size() == 64) begin
      chk("last_addr", 32'(got_q[63].a), 63);
      chk("last_data", got_q[63].d, 32'h3f);
    end

    // reset mid-word
    do_reset();
    part = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_stream(part, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_ready", 32'(in_ready), 1);
    chk("midrst_core_rst", 32'(core_rst), 1);
    repeat (10) @(negedge clk);
    chk("midrst_nwrites", got_q.size(), 1);
    run_stream(s3, 30);

    // randomized table
    vecs[0] = '{1, 0, 0, 1, 0};
    vecs[1] = '{2, 50, 0, 1, 0};
    vecs[2] = '{5, 70, 0, 1, 0};
    vecs[3] = '{63, 20, 0, 1, 0};
    vecs[4] = '{64, 40, 0, 1, 0};
    vecs[5] = '{65, 30, 0, 0, 1};
    vecs[6] = '{300, 0, 0, 0, 1};
    vecs[7] = '{0, 60, 0, 1, 0};
    vecs[8] = '{int'($urandom_range(1, N)), 50, 0, 1, 0};
    foreach (vecs[i]) run_vec(vecs[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_imem_loader.md
# riscv_imem_loader

Byte-stream program loader for the RISC-V core's instruction memory. It accepts a length-prefixed little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words and writes them to consecutive word addresses of instruction memory. It holds the core in reset while loading and releases it once the last word is written. This is the hardware writer for the memory the core fetches from, replacing backdoor memory preloads on boards and in system-level benches.

## Interface
- N_WORDS, default 64: instruction memory depth in 32-bit words; must be a power of two, at least 2.
- AW, default $clog2(N_WORDS): word-address width; derived, do not override.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte; a byte transfers on a rising edge where in_valid & in_ready.
- mem_we  out  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr  out  AW  word address of the write, valid while mem_we=1.
- mem_wd  out  32  write data, valid while mem_we=1.
- core_rst  out  1  reset to the core, active-high.
- done  out  1  load completed successfully; sticky until rst.
- err  out  1  load rejected; sticky until rst.

## Operation
- Stream format: CNT_LO, CNT_HI (16-bit word count, little-endian), then CNT×4 data bytes. Each word is sent least-significant byte first; byte i of a word lands in mem_wd[8i+7:8i].
- FSM states:
  - LEN0: accept CNT_LO, then go to LEN1.
  - LEN1: accept CNT_HI. If CNT==0, go to DONE. If CNT>N_WORDS, go to ERR. Otherwise go to DATA.
  - DATA: accept bytes into a 2-bit byte counter and a 32-bit shift/assembly register. After the 4th byte, go to WRITE.
  - WRITE: one cycle with mem_we=1, mem_addr=word counter, mem_wd=assembled word. The word counter then increments. If the counter was CNT−1, go to DONE; else go back to DATA with the byte counter at 0.
  - DONE and ERR: terminal until rst; in_ready=0.
- in_ready=1 only in LEN0, LEN1 and DATA. Bytes presented in any other state are not consumed.
- core_rst=1 in every state except DONE.
- done=1 only in DONE; err=1 only in ERR.
- Outputs are decoded from registered state and counters, with no combinational path from in_valid. in_ready does not depend on in_valid.
- CNT==N_WORDS is legal: the last write goes to address N_WORDS−1 and the word counter is not allowed to wrap into a further write.
- Word counter width is 16 bits, internal; mem_addr is its low AW bits.
- The block checks nothing else; stream content is not validated.

## Timing
- Reset values, including the cycle rst is sampled high: state=LEN0, byte and word counters=0, mem_we=0, mem_addr=0, mem_wd=0, core_rst=1, done=0, err=0, in_ready=1 from the first cycle after rst deasserts.
- rst at any point, including mid-word, mid-WRITE or in DONE/ERR, returns to LEN0 on the next edge. The partial word is discarded and core_rst reasserts.
- Latency: the 4th byte of a word is accepted at edge E; mem_we is high for the cycle after E, with in_ready=0 in that cycle.
- Peak throughput: 4 bytes per 5 cycles.
- Gaps on in_valid are allowed anywhere; state holds and nothing is lost.
- After the final WRITE cycle, done=1 and core_rst=0 from the following cycle, simultaneously.
- For CNT==0: done=1 and core_rst=0 in the cycle after CNT_HI is accepted.
- For CNT>N_WORDS: err=1 in the cycle after CNT_HI is accepted. No mem_we is ever asserted and core_rst stays 1.

## Test plan
- Load 3 words with in_valid held high. Stream: 03 00 63 4e 02 02 63 4c 00 02 63 48 40 00. Required: exactly three mem_we pulses, at addr0=0x02024e63, addr1=0x02004c63, addr2=0x00404863. done and core_rst=0 assert one cycle after the third pulse, then stay stable.
- Same stream with in_valid randomly deasserted about 50% of cycles. Required: identical writes and final state; in_ready=0 during each WRITE cycle.
- Count 0 (stream 00 00). Required: no mem_we; done=1 and core_rst=0 in the cycle after the second byte; in_ready=0 afterwards.
- N_WORDS=64, count 65 (stream 41 00). Required: err=1, no mem_we, core_rst stays 1, in_ready=0. Then pulse rst and load count 64 with words 0..63 equal to their index. Required: 64 writes, last at addr 63 with data 0x0000003f, then done=1.
- rst asserted after 2 data bytes of word 1 of a 3-word load. Required: no further mem_we, core_rst=1, state back to LEN0. A fresh full load afterwards writes correctly from addr 0.
- Bytes presented after done. Required: never accepted (in_ready=0), no mem_we, done stays 1.
